seg7_scan_driver: RTL and testbench

Parametrised multiplexed driver for a common-anode N-digit seven-segment display. It time-division scans NDIGITS hex nibbles onto one shared segment bus, using the team's standard segment encoding. It adds per-digit decimal points, a per-digit enable mask, leading-zero suppression, an inter-digit blanking gap against ghosting, and frame-coherent input capture. It sits between the clock/counter datapath and the board's segment and anode pins.

---
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with frame-coherent input capture,
// per-digit decimal points and enables, leading-zero suppression and an inter-digit blanking gap.
module seg7_scan_driver #(
  parameter int NDIGITS      = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   x,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   lz,
  output logic [6:0]             a_to_g,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NDIGITS - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIGITS-1:0] x_sh_q, x_sh_d;
  logic [NDIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NDIGITS-1:0]   en_sh_q, en_sh_d;
  logic                 lz_sh_q, lz_sh_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 tick_q, tick_d;

  logic                 snap;
  logic                 all_zero;
  logic [NDIGITS-1:0]   supp;
  logic [NDIGITS-1:0]   sel;
  logic [3:0]           cur_val;
  logic                 cur_dp;
  logic                 cur_vis;

  function automatic logic [6:0] encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // The snapshot edge is the start of slot 0; its outputs are blank anyway.
    snap    = (cnt_q == '0) && (idx_q == '0);
    x_sh_d  = snap ? x        : x_sh_q;
    dp_sh_d = snap ? dp_in    : dp_sh_q;
    en_sh_d = snap ? digit_en : en_sh_q;
    lz_sh_d = snap ? lz       : lz_sh_q;
    tick_d  = snap;

    // Suppression walks down from the most significant digit until a nonzero value or a dp.
    all_zero = 1'b1;
    supp     = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (x_sh_q[4*i +: 4] == 4'h0) & ~dp_sh_q[i];
      supp[i]  = lz_sh_q & all_zero & (i > 0);
    end

    sel     = '0;
    cur_val = 4'h0;
    cur_dp  = 1'b0;
    cur_vis = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i]  = 1'b1;
        cur_val = x_sh_q[4*i +: 4];
        cur_dp  = dp_sh_q[i];
        cur_vis = en_sh_q[i] & ~supp[i];
      end
    end

    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if ((cnt_q >= BLANK_END) && cur_vis) begin
      an_d  = ~sel;
      seg_d = encode(cur_val);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      x_sh_q  <= '0;
      dp_sh_q <= '0;
      en_sh_q <= '0;
      lz_sh_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      x_sh_q  <= x_sh_d;
      dp_sh_q <= dp_sh_d;
      en_sh_q <= en_sh_d;
      lz_sh_q <= lz_sh_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots and a 2-cycle blanking gap.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int tests;
  int failures;

  seg7_scan_driver #(
    .NDIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .lz(lz),
    .a_to_g(a_to_g),
    .dp(dp),
    .an(an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " an"}, {4'h0, an}, 8'h0F);
    check_output({tag, " seg"}, {1'b0, a_to_g}, 8'h7F);
    check_output({tag, " dp"}, {7'h0, dp}, 8'h01);
    check_output({tag, " tick"}, {7'h0, frame_tick}, 8'h00);
  endtask

  // Consumes the 8 samples of one slot, starting with the sample for cnt=0.
  task automatic check_slot(input string tag, input int slot, input logic [6:0] seg_exp,
                            input logic dp_exp, input logic vis);
    logic [3:0] an_exp;
    logic       on;
    string      t;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      on     = vis && (c >= 2);
      an_exp = 4'b1111;
      if (on) an_exp[slot] = 1'b0;
      t = $sformatf("%s s%0d c%0d", tag, slot, c);
      check_output({t, " an"}, {4'h0, an}, {4'h0, an_exp});
      check_output({t, " seg"}, {1'b0, a_to_g}, {1'b0, on ? seg_exp : 7'b1111111});
      check_output({t, " dp"}, {7'h0, dp}, {7'h0, on ? dp_exp : 1'b1});
      check_output({t, " tick"}, {7'h0, frame_tick}, {7'h0, (slot == 0 && c == 0)});
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] xv, input logic [3:0] dpv,
                                input logic [3:0] env, input logic lzv);
    x        = xv;
    dp_in    = dpv;
    digit_en = env;
    lz       = lzv;
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    apply_stimulus(16'h12AF, 4'b0000, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_values("reset held");
    rst_n = 1'b1;

    // Frame 1: first snapshot after release.
    check_slot("f1", 0, 7'b0111000, 1'b1, 1'b1);
    check_slot("f1", 1, 7'b0001000, 1'b1, 1'b1);
    check_slot("f1", 2, 7'b0010010, 1'b1, 1'b1);
    check_slot("f1", 3, 7'b1001111, 1'b1, 1'b1);

    // Frame 2: input changes mid-frame must not tear it.
    check_slot("f2", 0, 7'b0111000, 1'b1, 1'b1);
    apply_stimulus(16'h3456, 4'b0000, 4'b1111, 1'b0);
    check_slot("f2", 1, 7'b0001000, 1'b1, 1'b1);
    check_slot("f2", 2, 7'b0010010, 1'b1, 1'b1);
    check_slot("f2", 3, 7'b1001111, 1'b1, 1'b1);

    check_slot("f3", 0, 7'b0100000, 1'b1, 1'b1);
    check_slot("f3", 1, 7'b0100100, 1'b1, 1'b1);
    check_slot("f3", 2, 7'b1001100, 1'b1, 1'b1);
    check_slot("f3", 3, 7'b0000110, 1'b1, 1'b1);

    apply_stimulus(16'h0005, 4'b0000, 4'b1111, 1'b1);
    check_slot("f4 lz", 0, 7'b0100100, 1'b1, 1'b1);
    check_slot("f4 lz", 1, 7'b0000001, 1'b1, 1'b0);
    check_slot("f4 lz", 2, 7'b0000001, 1'b1, 1'b0);
    check_slot("f4 lz", 3, 7'b0000001, 1'b1, 1'b0);

    apply_stimulus(16'h0005, 4'b0010, 4'b1111, 1'b1);
    check_slot("f5 lzdp", 0, 7'b0100100, 1'b1, 1'b1);
    check_slot("f5 lzdp", 1, 7'b0000001, 1'b0, 1'b1);
    check_slot("f5 lzdp", 2, 7'b0000001, 1'b1, 1'b0);
    check_slot("f5 lzdp", 3, 7'b0000001, 1'b1, 1'b0);

    apply_stimulus(16'h0000, 4'b0000, 4'b1111, 1'b1);
    check_slot("f6 zero", 0, 7'b0000001, 1'b1, 1'b1);
    check_slot("f6 zero", 1, 7'b0000001, 1'b1, 1'b0);
    check_slot("f6 zero", 2, 7'b0000001, 1'b1, 1'b0);
    check_slot("f6 zero", 3, 7'b0000001, 1'b1, 1'b0);

    apply_stimulus(16'h12AF, 4'b0000, 4'b0101, 1'b0);
    check_slot("f7 en", 0, 7'b0111000, 1'b1, 1'b1);
    check_slot("f7 en", 1, 7'b0001000, 1'b1, 1'b0);
    check_slot("f7 en", 2, 7'b0010010, 1'b1, 1'b1);
    check_slot("f7 en", 3, 7'b1001111, 1'b1, 1'b0);

    // Frame 8: reset asserted during slot 2's on phase, between clock edges.
    check_slot("f8", 0, 7'b0111000, 1'b1, 1'b1);
    check_slot("f8", 1, 7'b0001000, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("f8 pre-reset an", {4'h0, an}, 8'h0B);
    check_output("f8 pre-reset seg", {1'b0, a_to_g}, 8'h12);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async reset");
    apply_stimulus(16'h3456, 4'b0000, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_values("reset held again");
    rst_n = 1'b1;

    check_slot("after reset", 0, 7'b0100000, 1'b1, 1'b1);
    check_slot("after reset", 1, 7'b0100100, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
